// File: rtl/seq_slice_comparator.sv
// seq_slice_comparator: multi-cycle MSB-first slice magnitude comparator with valid/ready in and out
// SEQ_SLICE_COMPARATOR_EARLY_EXIT_EN stops at the first differing slice instead of walking all slices
module seq_slice_comparator #(
   parameter int WIDTH = 64,
   parameter int SLICE = 16
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic [WIDTH-1:0]                        a,
   input  logic [WIDTH-1:0]                        b,
   input  logic                                    signed_mode,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic                                    gt,
   output logic                                    eq,
   output logic                                    lt,
   output logic [$clog2(WIDTH/SLICE+1)-1:0]        slices_used
);
   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW = $clog2(NSLICE + 1);
   localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
   localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

   state_t state, nxt;
   logic rdy_q, fin, sgt, slt, ngt, nlt;
   logic [IW-1:0] idx;
   logic [WIDTH-1:0] a_q, b_q;
   logic [SLICE-1:0] sa, sb;

   generate
      if (SLICE < 1 || SLICE > WIDTH || WIDTH % (SLICE > 0 ? SLICE : 1) != 0) begin : g_bad
         $error("seq_slice_comparator: WIDTH must be a non-zero multiple of SLICE");
      end
   endgenerate

   assign sa = a_q[int'(idx)*SLICE +: SLICE];
   assign sb = b_q[int'(idx)*SLICE +: SLICE];
   assign sgt = sa > sb;
   assign slt = sa < sb;

`ifdef SEQ_SLICE_COMPARATOR_EARLY_EXIT_EN
   assign fin = sgt || slt || idx == '0;
   assign ngt = sgt;
   assign nlt = slt;
`else
   logic pgt, plt;
   // the first differing slice from the MSB wins; later slices cannot override it
   assign fin = idx == '0;
   assign ngt = pgt || (!plt && sgt);
   assign nlt = plt || (!pgt && slt);

   always_ff @(posedge clk)
      if (!rst_n || in_ready) begin
         pgt <= 1'b0;
         plt <= 1'b0;
      end else if (state == CMP) begin
         pgt <= ngt;
         plt <= nlt;
      end
`endif

   always_ff @(posedge clk)
      if (!rst_n) state <= IDLE;
      else state <= nxt;

   always_comb
      nxt = state == IDLE ? (in_valid && rdy_q ? CMP : IDLE)
          : state == CMP  ? (fin ? DONE : CMP)
          : (out_ready ? IDLE : DONE);

   // rdy_q keeps in_ready low for the cycle following a reset edge
   always_comb begin
      in_ready = state == IDLE && rdy_q;
      out_valid = state == DONE;
   end

   always_ff @(posedge clk)
      if (!rst_n) begin
         rdy_q <= 1'b0;
         idx <= IW'(NSLICE - 1);
         gt <= 1'b0;
         eq <= 1'b0;
         lt <= 1'b0;
         slices_used <= '0;
      end else begin
         rdy_q <= 1'b1;
         if (in_ready && in_valid) begin
            a_q <= a ^ (signed_mode ? MSB : '0);
            b_q <= b ^ (signed_mode ? MSB : '0);
            idx <= IW'(NSLICE - 1);
         end
         if (state == CMP) begin
            if (fin) begin
               gt <= ngt;
               lt <= nlt;
               eq <= !ngt && !nlt;
               slices_used <= CW'(NSLICE - int'(idx));
            end else
               idx <= idx - 1'b1;
         end
         if (out_valid && out_ready) begin
            gt <= 1'b0;
            eq <= 1'b0;
            lt <= 1'b0;
         end
      end
endmodule

// File: tb/tb_seq_slice_comparator.sv
// tb_seq_slice_comparator: transaction-level reference model plus directed literal cases and random traffic
module tb_seq_slice_comparator;
   localparam int WIDTH = 64;
   localparam int SLICE = 16;
   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW = $clog2(NSLICE + 1);
`ifdef SEQ_SLICE_COMPARATOR_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, signed_mode = 1'b0, out_ready = 1'b0;
   logic [WIDTH-1:0] a = '0, b = '0;
   logic in_ready, out_valid, gt, eq, lt;
   logic [CW-1:0] slices_used;

   int checks = 0, errors = 0;

   int ph = 0, age = 0, km = 0;
   bit rdy = 1'b0;
   logic [2:0] res = '0;
   logic [CW-1:0] su_m = '0;

   seq_slice_comparator #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
      .out_ready(out_ready), .gt(gt), .eq(eq), .lt(lt), .slices_used(slices_used)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] cmp_ref(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit sm);
      bit g, l;
      g = sm ? $signed(x) > $signed(y) : x > y;
      l = sm ? $signed(x) < $signed(y) : x < y;
      return {g, x == y, l};
   endfunction

   function automatic int slices_ref(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      if (!EARLY) return NSLICE;
      for (int i = NSLICE - 1; i >= 0; i--)
         if (x[i*SLICE +: SLICE] != y[i*SLICE +: SLICE]) return NSLICE - i;
      return NSLICE;
   endfunction

   // ph: 0 waiting for operands, 1 comparing (age edges since accept), 2 result offered
   always @(posedge clk) begin
      if (!rst_n) begin
         ph = 0;
         rdy = 1'b0;
         su_m = '0;
      end else begin
         if (ph == 0 && rdy && in_valid) begin
            res = cmp_ref(a, b, signed_mode);
            km = slices_ref(a, b);
            age = 0;
            ph = 1;
         end else if (ph == 1) begin
            age++;
            if (age == km) begin
               ph = 2;
               su_m = CW'(km);
            end
         end else if (ph == 2 && out_ready)
            ph = 0;
         rdy = 1'b1;
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit sm, output int lat);
      int n;
      in_valid = 1'b1;
      a = x;
      b = y;
      signed_mode = sm;
      n = 0;
      while (!in_ready && n < 50) begin
         tick;
         n++;
      end
      chk("accept_wait", 64'(n < 50), 64'(1));
      tick;
      in_valid = 1'b0;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      lat = 0;
      while (!out_valid && lat < 50) begin
         tick;
         lat++;
      end
   endtask

   task automatic directed(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input bit sm, input logic [2:0] flags, input int su);
      int lat;
      send(x, y, sm, lat);
      chk($sformatf("%s_flags", name), 64'({gt, eq, lt}), 64'(flags));
      chk($sformatf("%s_slices", name), 64'(slices_used), 64'(su));
      chk($sformatf("%s_latency", name), 64'(lat), 64'(su));
      tick;
      chk($sformatf("%s_release", name), 64'({out_valid, in_ready}), 64'(2'b01));
   endtask

   initial begin
      int lat;
      logic [WIDTH-1:0] x, y;
      out_ready = 1'b1;
      repeat (3) tick;
      fork
         forever begin
            logic [CW+4:0] got, exp;
            @(negedge clk);
            exp = {ph == 0 && rdy, ph == 2, ph == 2 ? res : 3'b000, su_m};
            got = {in_ready, out_valid, gt, eq, lt, slices_used};
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL model t=%0t rdy/ov/gt/eq/lt/su got %b expected %b", $time, got, exp);
            end
         end
      join_none

      chk("reset_outputs", 64'({in_ready, out_valid, gt, eq, lt, slices_used}), 64'(0));
      rst_n = 1'b1;
      chk("ready_low_at_release", 64'(in_ready), 64'(0));
      tick;
      chk("ready_after_reset", 64'(in_ready), 64'(1));

      // equal operands, then hold the result under backpressure
      out_ready = 1'b0;
      send(64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0, lat);
      chk("c1_flags", 64'({gt, eq, lt}), 64'(3'b010));
      chk("c1_slices", 64'(slices_used), 64'(4));
      chk("c1_latency", 64'(lat), 64'(4));
      in_valid = 1'b1;
      a = 64'h1;
      b = 64'h0;
      repeat (5) begin
         tick;
         chk("bp_hold", 64'({out_valid, eq, in_ready}), 64'(3'b110));
      end
      out_ready = 1'b1;
      tick;
      chk("bp_release", 64'({out_valid, in_ready}), 64'(2'b01));
      in_valid = 1'b0;
      tick;
      chk("bp_not_captured", 64'({out_valid, in_ready}), 64'(2'b01));

      directed("c2u", 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b100, EARLY ? 1 : 4);
      directed("c2s", 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 3'b001, EARLY ? 1 : 4);
      directed("c3u", 64'h2, 64'h3, 1'b0, 3'b001, 4);
      directed("c3s", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 3'b001, EARLY ? 1 : 4);
      directed("eqs", 64'hDEAD_BEEF_0000_FFFF, 64'hDEAD_BEEF_0000_FFFF, 1'b1, 3'b010, 4);
      directed("mid", 64'h0000_0005_0000_0000, 64'h0000_0004_FFFF_FFFF, 1'b1, 3'b100, EARLY ? 2 : 4);

      // abort a compare with reset
      in_valid = 1'b1;
      a = 64'h2;
      b = 64'h3;
      signed_mode = 1'b0;
      tick;
      in_valid = 1'b0;
      tick;
      rst_n = 1'b0;
      tick;
      chk("abort_outputs", 64'({in_ready, out_valid, gt, eq, lt}), 64'(0));
      rst_n = 1'b1;
      tick;
      chk("abort_ready", 64'(in_ready), 64'(1));
      repeat (8) begin
         tick;
         chk("abort_no_result", 64'(out_valid), 64'(0));
      end

      repeat (3000) begin
         x = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0: y = {$urandom, $urandom};
            1: y = x;
            2: begin y = x; y[$urandom_range(0, NSLICE - 1)*SLICE +: SLICE] = 16'($urandom); end
            default: begin y = x; y[WIDTH-1] = ~y[WIDTH-1]; end
         endcase
         a = x;
         b = y;
         signed_mode = 1'($urandom);
         in_valid = $urandom_range(0, 2) != 0;
         out_ready = $urandom_range(0, 3) != 0;
         rst_n = $urandom_range(0, 299) != 0;
         tick;
      end
      rst_n = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (10) tick;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
